// File: rtl/sld_pkg.sv
// Shared constants and state encoding for the scene-data stream sequencer.
// The ROM instance beside the controller uses the same depth and address width.
package sld_pkg;

  localparam int SLD_DEPTH = 1501;
  localparam int SLD_AW    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } sld_state_t;

endpackage

// File: rtl/sld_stream_ctrl.sv
// Owns the scene-data ROM address and streams 1 or 4 big-endian bytes per request
// over a valid/ready response, with rewind and end-of-data saturation.
//
// state | meaning
// IDLE  | waiting for req; ptr holds the next byte to read
// FETCH | one ROM byte shifted into acc per cycle, cnt bytes remaining after this one
// RESP  | rdata/rvalid held until rready
module sld_stream_ctrl
  import sld_pkg::*;
#(
  parameter int DEPTH = SLD_DEPTH,
  parameter int AW    = SLD_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req,
  input  logic          word,
  input  logic          rewind,
  output logic [31:0]   rdata,
  output logic          rvalid,
  input  logic          rready,
  output logic          busy,
  output logic          eod,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_rd
);

  localparam logic [AW-1:0] PTR_END   = AW'(DEPTH);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  sld_state_t    r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic [AW-1:0] r_rom_addr, w_rom_addr_nxt;
  logic [23:0]   r_acc, w_acc_nxt;
  logic [31:0]   r_rdata, w_rdata_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic          r_eod, w_eod_nxt;
  logic          w_in_range;
  logic [7:0]    w_byte;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_acc_nxt   = r_acc;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    w_in_range  = (r_ptr < PTR_END);
    w_byte      = w_in_range ? rom_rd : 8'h00;

    if (rewind) begin
      w_state_nxt = IDLE;
      w_ptr_nxt   = '0;
      w_acc_nxt   = '0;
      w_rdata_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req) begin
            w_cnt_nxt   = word ? 2'd3 : 2'd0;
            w_acc_nxt   = '0;
            w_state_nxt = FETCH;
          end
        end
        FETCH: begin
          w_acc_nxt = {r_acc[15:0], w_byte};
          if (w_in_range) w_ptr_nxt = r_ptr + 1'b1;
          if (r_cnt == 2'd0) begin
            // acc was cleared on accept, so a single byte lands zero-extended
            w_rdata_nxt = {r_acc, w_byte};
            w_state_nxt = RESP;
          end else begin
            w_cnt_nxt = r_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rready) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    // Address follows the pointer but never leaves the populated ROM range
    w_rom_addr_nxt = (w_ptr_nxt >= PTR_END) ? ADDR_LAST : w_ptr_nxt;
    w_eod_nxt      = (w_ptr_nxt == PTR_END);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_acc      <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_eod      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_acc      <= w_acc_nxt;
      r_rdata    <= w_rdata_nxt;
      r_cnt      <= w_cnt_nxt;
      r_eod      <= w_eod_nxt;
    end
  end

  assign rdata    = r_rdata;
  assign rvalid   = (r_state == RESP);
  assign busy     = (r_state != IDLE);
  assign eod      = r_eod;
  assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_sld_stream_ctrl.sv
// Directed bench for sld_stream_ctrl against a behavioural ROM holding RAM[i] = i[7:0].
module tb_sld_stream_ctrl;
  import sld_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        word = 1'b0;
  logic        rewind = 1'b0;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        eod;
  logic [11:0] rom_addr;
  logic [7:0]  rom_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int max_addr = 0;

  always #5 clk = ~clk;

  assign rom_rd = rom_addr[7:0];

  always @(negedge clk) if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);

  sld_stream_ctrl dut (
    .clk(clk), .rstn(rstn), .req(req), .word(word), .rewind(rewind),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .busy(busy), .eod(eod),
    .rom_addr(rom_addr), .rom_rd(rom_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request issued just after an edge, accepted at the next edge T; rvalid must be
  // visible after edge T+1 (byte) or T+4 (word), i.e. sampled high at edge T+2 / T+5.
  task automatic fetch(input logic w, input logic [31:0] exp, input string tag);
    int k;
    req  = 1'b1;
    word = w;
    step();
    req  = 1'b0;
    check({tag, " busy@T"}, {31'd0, busy}, 32'd1);
    check({tag, " rvalid@T"}, {31'd0, rvalid}, 32'd0);
    k = 0;
    while (rvalid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check({tag, " latency"}, k, w ? 32'd4 : 32'd1);
    check({tag, " rdata"}, rdata, exp);
    rready = 1'b1;
    step();
    check({tag, " rvalid drop"}, {31'd0, rvalid}, 32'd0);
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
  endtask

  initial begin
    #12;
    check("reset rdata", rdata, 32'd0);
    check("reset rvalid", {31'd0, rvalid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset eod", {31'd0, eod}, 32'd0);
    check("reset rom_addr", {20'd0, rom_addr}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    fetch(1'b0, 32'h00, "byte0");
    fetch(1'b0, 32'h01, "byte1");
    fetch(1'b0, 32'h02, "byte2");
    check("ptr after bytes", {20'd0, rom_addr}, 32'd3);

    do_rewind();
    check("rewind ptr", {20'd0, rom_addr}, 32'd0);
    fetch(1'b1, 32'h00010203, "word0");
    fetch(1'b1, 32'h04050607, "word1");
    check("ptr after words", {20'd0, rom_addr}, 32'd8);

    rready = 1'b0;
    req = 1'b1;
    word = 1'b0;
    step();
    req = 1'b0;
    step();
    check("bp rvalid", {31'd0, rvalid}, 32'd1);
    check("bp rdata", rdata, 32'h08);
    for (int i = 0; i < 10; i++) begin
      req  = i[0];
      word = 1'b1;
      step();
      check("bp hold rvalid", {31'd0, rvalid}, 32'd1);
      check("bp hold rdata", rdata, 32'h08);
      check("bp hold ptr", {20'd0, rom_addr}, 32'd9);
    end
    req = 1'b0;
    rready = 1'b1;
    step();
    check("bp release rvalid", {31'd0, rvalid}, 32'd0);
    check("bp release ptr", {20'd0, rom_addr}, 32'd9);

    do_rewind();
    for (int i = 0; i < 1499; i++) fetch(1'b0, {24'd0, 8'(i)}, "walk");
    check("walk ptr", {20'd0, rom_addr}, 32'd1499);
    check("walk eod", {31'd0, eod}, 32'd0);
    fetch(1'b1, 32'hDBDC0000, "tail word");
    check("tail eod", {31'd0, eod}, 32'd1);
    check("tail rom_addr", {20'd0, rom_addr}, 32'd1500);
    fetch(1'b0, 32'h00, "past end byte");
    check("past end eod", {31'd0, eod}, 32'd1);
    check("past end rom_addr", {20'd0, rom_addr}, 32'd1500);
    check("max rom_addr", max_addr, 32'd1500);

    do_rewind();
    check("rewind eod", {31'd0, eod}, 32'd0);
    check("rewind addr", {20'd0, rom_addr}, 32'd0);

    req = 1'b1;
    word = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    check("mid word ptr", {20'd0, rom_addr}, 32'd2);
    check("mid word busy", {31'd0, busy}, 32'd1);
    rewind = 1'b1;
    req = 1'b1;
    step();
    rewind = 1'b0;
    req = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort rvalid", {31'd0, rvalid}, 32'd0);
    check("abort ptr", {20'd0, rom_addr}, 32'd0);
    step();
    check("abort req ignored", {31'd0, busy}, 32'd0);
    fetch(1'b0, 32'h00, "after abort");
    check("after abort ptr", {20'd0, rom_addr}, 32'd1);

    rready = 1'b0;
    req = 1'b1;
    word = 1'b0;
    step();
    req = 1'b0;
    step();
    check("pre reset rvalid", {31'd0, rvalid}, 32'd1);
    check("pre reset rdata", rdata, 32'h01);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async rdata", rdata, 32'd0);
    check("async rvalid", {31'd0, rvalid}, 32'd0);
    check("async busy", {31'd0, busy}, 32'd0);
    check("async eod", {31'd0, eod}, 32'd0);
    check("async rom_addr", {20'd0, rom_addr}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rready = 1'b1;
    step();
    fetch(1'b0, 32'h00, "after reset");
    check("after reset ptr", {20'd0, rom_addr}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
